// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Command decoder sitting behind an SPI slave byte receiver. Each received
//   byte is consumed with a one-cycle read_ack pulse. Chip-select framed byte
//   streams are decoded as register read / write commands against a small
//   bank of 8-bit control registers.
//
//   Command byte: bit7 = 1 write / 0 read, bits[6:4] ignored, bits[3:0] addr.
//   Reads place the selected register (or ID_VALUE at addr 4'hF) on
//   data_to_send, which the SPI slave shifts out in the first byte of the
//   next frame. Writes take the following byte as data.
//
//   Optional build macro SPI_REG_BRIDGE_AUTOINC_EN: burst writes. Every data
//   byte after a write command goes to the next address until the bank ends.
//
// Handshake: a byte is taken when data_ready=1 and read_ack=0; read_ack is
//   registered high for exactly one cycle and the byte is decoded in that
//   ack cycle, so results (reg_q, wr_strobe, data_to_send, cmd_error) appear
//   on the cycle after the ack.
//
// Ports:
//   system_clk    in   clock, rising edge
//   rst_n         in   synchronous active-low reset
//   spi_cs        in   SPI chip select (active low, asynchronous)
//   data_ready    in   byte available from the SPI slave (level)
//   received_data in   received byte
//   read_ack      out  one-cycle byte consume pulse
//   data_to_send  out  byte returned in the next frame
//   reg_q         out  register bank, reg n at [8n+7:8n]
//   wr_strobe     out  one-cycle pulse per register write
//   cmd_error     out  sticky command error flag
module spi_reg_bridge #(
    parameter int         NUM_REGS = 4,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic                  system_clk,
    input  logic                  rst_n,
    input  logic                  spi_cs,
    input  logic                  data_ready,
    input  logic [7:0]            received_data,
    output logic                  read_ack,
    output logic [7:0]            data_to_send,
    output logic [NUM_REGS*8-1:0] reg_q,
    output logic [NUM_REGS-1:0]   wr_strobe,
    output logic                  cmd_error
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DISCARD   = 2'd2
    } state_t;

    // state is left as a plainly named signal so checkers can bind to it
    state_t               state, state_nxt;
    logic                 cs_meta, cs_s;
    logic                 frame_valid;
    logic [7:0]           byte_q;
    logic [3:0]           addr, addr_nxt;
    logic [7:0]           regs     [NUM_REGS];
    logic [7:0]           regs_nxt [NUM_REGS];
    logic [7:0]           dts_nxt;
    logic                 err_nxt;
    logic [NUM_REGS-1:0]  strobe_nxt;
    logic                 accept;
    logic                 process_byte;
    logic [3:0]           cmd_addr;
    logic                 cmd_is_reg;
    logic [7:0]           cmd_rdata;

    // The upstream flag is still high during the ack cycle, so accepting
    // only while read_ack is low gives exactly one ack per byte.
    assign accept       = data_ready & ~read_ack;
    // Bytes after a reset that landed mid-frame are dropped until the
    // frame has been closed once.
    assign process_byte = read_ack & frame_valid;
    assign cmd_addr     = byte_q[3:0];
    assign cmd_is_reg   = (32'(cmd_addr) < NUM_REGS);

    always_comb begin
        cmd_rdata = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == 4'(i)) cmd_rdata = regs[i];
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*8 +: 8] = regs[i];
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        dts_nxt    = data_to_send;
        err_nxt    = cmd_error;
        strobe_nxt = '0;
        regs_nxt   = regs;

        if (process_byte) begin
            case (state)
                IDLE: begin
                    if (!byte_q[7]) begin
                        if (cmd_is_reg) begin
                            dts_nxt = cmd_rdata;
                        end else if (cmd_addr == 4'hF) begin
                            dts_nxt = ID_VALUE;
                            err_nxt = 1'b0;
                        end else begin
                            dts_nxt = 8'h00;
                            err_nxt = 1'b1;
                        end
                        state_nxt = DISCARD;
                    end else if (cmd_is_reg) begin
                        addr_nxt  = cmd_addr;
                        state_nxt = WAIT_DATA;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = DISCARD;
                    end
                end
                WAIT_DATA: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr == 4'(i)) begin
                            regs_nxt[i]   = byte_q;
                            strobe_nxt[i] = 1'b1;
                        end
                    end
                    dts_nxt = byte_q;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
                    // Stop the burst as soon as the bank is exhausted.
                    if (32'(addr) + 1 >= NUM_REGS) begin
                        err_nxt   = 1'b1;
                        state_nxt = DISCARD;
                    end else begin
                        addr_nxt  = addr + 4'd1;
                    end
`else
                    state_nxt = DISCARD;
`endif
                end
                default: ;
            endcase
        end

        // Frame end wins over everything, but only after the byte in the
        // same cycle (if any) has been decoded above.
        if (cs_s) state_nxt = IDLE;
    end

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            cs_meta      <= 1'b1;
            cs_s         <= 1'b1;
            frame_valid  <= 1'b0;
            read_ack     <= 1'b0;
            byte_q       <= 8'h00;
            state        <= IDLE;
            addr         <= 4'h0;
            data_to_send <= 8'h00;
            cmd_error    <= 1'b0;
            wr_strobe    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            cs_meta      <= spi_cs;
            cs_s         <= cs_meta;
            if (cs_s) frame_valid <= 1'b1;
            read_ack     <= accept;
            if (accept) byte_q <= received_data;
            state        <= state_nxt;
            addr         <= addr_nxt;
            data_to_send <= dts_nxt;
            cmd_error    <= err_nxt;
            wr_strobe    <= strobe_nxt;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_nxt[i];
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Testbench for spi_reg_bridge (NUM_REGS=4, ID_VALUE=8'hA5).
// Works in both the default build and with SPI_REG_BRIDGE_AUTOINC_EN.
module tb_spi_reg_bridge;

    logic        system_clk;
    logic        rst_n;
    logic        spi_cs;
    logic        data_ready;
    logic [7:0]  received_data;
    logic        read_ack;
    logic [7:0]  data_to_send;
    logic [31:0] reg_q;
    logic [3:0]  wr_strobe;
    logic        cmd_error;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int strobe_cnt = 0;

    spi_reg_bridge #(.NUM_REGS(4), .ID_VALUE(8'hA5)) dut (
        .system_clk   (system_clk),
        .rst_n        (rst_n),
        .spi_cs       (spi_cs),
        .data_ready   (data_ready),
        .received_data(received_data),
        .read_ack     (read_ack),
        .data_to_send (data_to_send),
        .reg_q        (reg_q),
        .wr_strobe    (wr_strobe),
        .cmd_error    (cmd_error)
    );

    // clock / reset
    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    // pulse monitor, sampled away from the active edge
    always @(negedge system_clk) begin
        if (rst_n) begin
            ack_cnt    = ack_cnt + (read_ack ? 1 : 0);
            strobe_cnt = strobe_cnt + $countones(wr_strobe);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // driver: present one byte, wait for its ack, drop the flag after the ack cycle
    task automatic send_byte(input logic [7:0] b);
        int lat;
        @(negedge system_clk);
        received_data = b;
        data_ready    = 1'b1;
        lat = 0;
        while (lat < 10) begin
            @(negedge system_clk);
            lat++;
            if (read_ack) break;
        end
        chk("ack_latency", 32'(lat), 32'd1);
        @(posedge system_clk);
        #1;
        data_ready = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge system_clk);
        spi_cs = 1'b0;
        repeat (4) @(negedge system_clk);
    endtask

    task automatic frame_end();
        repeat (3) @(negedge system_clk);
        spi_cs = 1'b1;
        repeat (4) @(negedge system_clk);
    endtask

    task automatic send_frame(input logic [31:0] bytes, input int n);
        logic [31:0] v;
        v = bytes;
        frame_start();
        for (int i = 0; i < n; i++) send_byte(v[i*8 +: 8]);
        frame_end();
    endtask

    typedef struct {
        string       name;
        logic [31:0] bytes;   // byte 0 in [7:0]
        int          n;
        logic [31:0] exp_reg_q;
        logic [7:0]  exp_dts;
        logic        exp_err;
        int          exp_strobes;
    } vec_t;

    vec_t vecs[11];

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    initial begin
        int a0, s0;

        vecs[0]  = '{"rd_reg1",     32'h00000001, 1, 32'h00003C00, 8'h3C, 1'b0, 0};
        vecs[1]  = '{"rd_id",       32'h0000000F, 1, 32'h00003C00, 8'hA5, 1'b0, 0};
        vecs[2]  = '{"rd_bad",      32'h00000007, 1, 32'h00003C00, 8'h00, 1'b1, 0};
        vecs[3]  = '{"rd_id_clr",   32'h0000000F, 1, 32'h00003C00, 8'hA5, 1'b0, 0};
        vecs[4]  = '{"wr_reg3",     32'h00007783, 2, 32'h77003C00, 8'h77, 1'b0, 1};
        vecs[5]  = '{"wr_rsv_bits", 32'h00005AF0, 2, 32'h77003C5A, 8'h5A, 1'b0, 1};
        vecs[6]  = '{"rd_reg2",     32'h00000002, 1, 32'h77003C5A, 8'h00, 1'b0, 0};
        vecs[7]  = '{"wr_bad",      32'h00009985, 2, 32'h77003C5A, 8'h00, 1'b1, 0};
        if (AUTOINC) begin
            vecs[8]  = '{"wr_two",  32'h00341280, 3, 32'h77003412, 8'h34, 1'b1, 2};
            vecs[9]  = '{"rd_id2",  32'h0000000F, 1, 32'h77003412, 8'hA5, 1'b0, 0};
            vecs[10] = '{"burst",   32'h33221182, 4, 32'h22113412, 8'h22, 1'b1, 2};
        end else begin
            vecs[8]  = '{"wr_two",  32'h00341280, 3, 32'h77003C12, 8'h12, 1'b1, 1};
            vecs[9]  = '{"rd_id2",  32'h0000000F, 1, 32'h77003C12, 8'hA5, 1'b0, 0};
            vecs[10] = '{"burst",   32'h33221182, 4, 32'h77113C12, 8'h11, 1'b0, 1};
        end

        rst_n = 1'b0;
        spi_cs = 1'b1;
        data_ready = 1'b0;
        received_data = 8'h00;
        repeat (3) @(negedge system_clk);
        chk("rst_read_ack", {31'b0, read_ack}, 32'd0);
        chk("rst_dts", {24'b0, data_to_send}, 32'd0);
        chk("rst_reg_q", reg_q, 32'd0);
        chk("rst_strobe", {28'b0, wr_strobe}, 32'd0);
        chk("rst_err", {31'b0, cmd_error}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge system_clk);

        // write reg1 with strobe timing
        a0 = ack_cnt;
        frame_start();
        send_byte(8'h81);
        chk("wr_no_early_strobe", {28'b0, wr_strobe}, 32'd0);
        send_byte(8'h3C);
        @(negedge system_clk);
        chk("wr_strobe_pulse", {28'b0, wr_strobe}, 32'h2);
        chk("wr_reg1", {24'b0, reg_q[15:8]}, 32'h3C);
        chk("wr_echo", {24'b0, data_to_send}, 32'h3C);
        @(negedge system_clk);
        chk("wr_strobe_end", {28'b0, wr_strobe}, 32'd0);
        frame_end();
        chk("wr_acks", 32'(ack_cnt - a0), 32'd2);

        // table
        foreach (vecs[k]) begin
            a0 = ack_cnt;
            s0 = strobe_cnt;
            send_frame(vecs[k].bytes, vecs[k].n);
            chk({vecs[k].name, "_reg_q"}, reg_q, vecs[k].exp_reg_q);
            chk({vecs[k].name, "_dts"}, {24'b0, data_to_send}, {24'b0, vecs[k].exp_dts});
            chk({vecs[k].name, "_err"}, {31'b0, cmd_error}, {31'b0, vecs[k].exp_err});
            chk({vecs[k].name, "_strobes"}, 32'(strobe_cnt - s0), 32'(vecs[k].exp_strobes));
            chk({vecs[k].name, "_acks"}, 32'(ack_cnt - a0), 32'(vecs[k].n));
        end

        // aborted write: command only, then read back reg2
        s0 = strobe_cnt;
        send_frame(32'h00000082, 1);
        chk("abort_reg_q", reg_q, vecs[10].exp_reg_q);
        chk("abort_err", {31'b0, cmd_error}, {31'b0, AUTOINC});
        send_frame(32'h00000002, 1);
        chk("abort_rd_reg2", {24'b0, data_to_send}, 32'h11);
        chk("abort_strobes", 32'(strobe_cnt - s0), 32'd0);

        // reset in the middle of a frame
        frame_start();
        send_byte(8'h81);
        @(negedge system_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge system_clk);
        chk("midrst_reg_q", reg_q, 32'd0);
        chk("midrst_dts", {24'b0, data_to_send}, 32'd0);
        chk("midrst_err", {31'b0, cmd_error}, 32'd0);
        rst_n = 1'b1;
        frame_end();
        s0 = strobe_cnt;
        send_frame(32'h00000001, 1);
        chk("postrst_rd_reg1", {24'b0, data_to_send}, 32'd0);
        chk("postrst_strobes", 32'(strobe_cnt - s0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Byte-level command decoder directly downstream of the SPI slave receiver.
- Consumes each received byte via the data_ready/read_ack handshake and interprets CS-delimited frames as register read/write commands.
- Drives a small bank of 8-bit control registers, e.g. LEDs and test outputs.
- Presents read-back data on data_to_send. The SPI slave loads that byte while CS is high, so read data returns in the first byte of the next frame.

Parameters:
- NUM_REGS, 4, number of R/W registers, 1..15, addresses 0..NUM_REGS-1.
- ID_VALUE, 8'hA5, constant returned on reads of address 4'hF.

Ports:
- system_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- spi_cs  in  1  SPI chip select, active low, asynchronous; frame delimiter.
- data_ready  in  1  byte-available flag from SPI slave; level, held until acked.
- received_data  in  8  received byte, valid while data_ready=1.
- read_ack  out  1  one-cycle pulse consuming the current byte.
- data_to_send  out  8  byte the SPI slave transmits at the start of the next frame.
- reg_q  out  NUM_REGS*8  register contents; reg n at bits [8n+7:8n].
- wr_strobe  out  NUM_REGS  one-cycle pulse on the cycle reg n updates.
- cmd_error  out  1  sticky error flag.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - read_ack=0, data_to_send=8'h00, reg_q=0, wr_strobe=0, cmd_error=0.
  - FSM=IDLE, CS synchroniser flops=1.
- CS sync: spi_cs passes through 2 flops (cs_s). A frame end is cs_s=1.
- Byte accept: when data_ready=1 and read_ack=0, register read_ack=1 for exactly one cycle and process received_data in that same cycle.
  - No further byte is accepted in the cycle after the ack, since the upstream flag clears then.
  - Ack latency: 1 cycle after data_ready is sampled high.
- Command byte format:
  - bit7 = 1 for write, 0 for read.
  - bits[6:4] reserved; ignored.
  - bits[3:0] = addr.
- FSM IDLE, on command byte:
  - Read, addr < NUM_REGS: data_to_send <= reg[addr]; go to DISCARD.
  - Read, addr == 4'hF: data_to_send <= ID_VALUE; clear cmd_error; go to DISCARD.
  - Read, other addr: data_to_send <= 8'h00; set cmd_error; go to DISCARD.
  - Write, addr < NUM_REGS: latch addr; go to WAIT_DATA.
  - Write, other addr: set cmd_error; go to DISCARD.
- FSM WAIT_DATA, on byte:
  - reg[addr] <= byte; wr_strobe[addr]=1 for one cycle.
  - data_to_send <= byte (write echo).
  - reg_q and wr_strobe change on the cycle after the ack cycle, i.e. 2 cycles after data_ready is seen.
  - Then go to DISCARD.
- FSM DISCARD: bytes are acked and ignored.
- Frame end: cs_s=1 in any state forces IDLE the next cycle.
  - A write whose data byte has not arrived is aborted: no register change, no strobe, cmd_error unchanged.
  - data_to_send holds its value across frames.
- Simultaneous events: if cs_s=1 and data_ready=1 in the same cycle, the byte is still acked and processed first; the FSM still ends in IDLE.
- Reset mid-frame: all state returns to reset values; the remainder of the frame is treated as if from IDLE once cs_s has been 1.
  - Bytes arriving while cs_s=0 after reset are ignored until a frame end. A frame_valid flag is cleared by reset and set by cs_s=1.
- Reserved command bits never cause an error.

Optional Feature:
- Macro: SPI_REG_BRIDGE_AUTOINC_EN.
- Defined (burst write): WAIT_DATA does not exit after the data byte.
  - Each further byte in the frame writes to addr+1, addr+2, …
  - When the next address would reach NUM_REGS: set cmd_error, go to DISCARD.
  - Each write pulses its own wr_strobe bit.
  - data_to_send echoes the last byte written.
- Undefined: behaviour exactly as above; bytes after the first data byte are discarded.

Test Plan:
- Reset, then frame {8'h81, 8'h3C} with NUM_REGS=4 -> reg_q[15:8]=8'h3C; wr_strobe=4'b0010 for 1 cycle; data_to_send=8'h3C; read_ack pulses once per byte.
- Frame {8'h01}, then a second frame -> data_to_send=8'h3C before the second frame starts; reg_q unchanged; no wr_strobe.
- Frame {8'h0F} -> data_to_send=8'hA5; cmd_error=0.
- Frame {8'h07} -> data_to_send=8'h00, cmd_error=1; then frame {8'h0F} -> cmd_error=0.
- Frame {8'h82} with CS deasserted before the data byte, then frame {8'h02} -> reg[2] still 8'h00; no strobe.
- Burst: frame {8'h82, 8'h11, 8'h22, 8'h33}.
  - AUTOINC defined: reg2=8'h11, reg3=8'h22, cmd_error=1, third data byte dropped.
  - AUTOINC undefined: only reg2=8'h11, cmd_error=0.
